// File: rtl/avalon_ram_pkg.sv
// Shared definitions for the wait-state Avalon-MM memory: FSM encoding and
// bus-level constants used by the RTL and the CPU benches.
package avalon_ram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_ACK   = 2'd2
   } state_e;

   localparam int          DEFAULT_LATENCY   = 2;
   localparam logic [31:0] MIPS_RESET_VECTOR = 32'hBFC00000;

endpackage

// File: rtl/avalon_wait_ram_if.sv
// Avalon-MM bus between the CPU master and the wait-state memory.
// Handshake: a transfer is accepted in the cycle where (read|write) is high and
// waitrequest is low; the master holds address/data/byteenable stable until then.
interface avalon_wait_ram_if;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [31:0] readdata;

   modport master (
      output address, read, write, byteenable, writedata,
      input  waitrequest, readdata
   );

   modport slave (
      input  address, read, write, byteenable, writedata,
      output waitrequest, readdata
   );
endinterface

// File: rtl/byte_lane_mem.sv
// Four 8-bit lane arrays with a masked bus write port, a full-word preload
// port that wins on address collision, and an asynchronous word read.
module byte_lane_mem #(
   parameter int ADDR_W = 10
) (
   input  logic              i_clk,
   input  logic [3:0]        i_bus_we,
   input  logic [ADDR_W-1:0] i_bus_addr,
   input  logic [31:0]       i_bus_wdata,
   input  logic              i_ld_en,
   input  logic [ADDR_W-1:0] i_ld_addr,
   input  logic [31:0]       i_ld_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [31:0]       o_rd_data
);
   localparam int DEPTH = 1 << ADDR_W;

   logic w_ld_hits_bus;
   assign w_ld_hits_bus = i_ld_en && (i_ld_addr == i_bus_addr);

   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [7:0] r_lane [DEPTH];

      // The bus write is suppressed when a preload targets the same word.
      always_ff @(posedge i_clk) begin
         if (i_bus_we[l] && !w_ld_hits_bus) begin
            r_lane[i_bus_addr] <= i_bus_wdata[8*l +: 8];
         end
         if (i_ld_en) begin
            r_lane[i_ld_addr] <= i_ld_data[8*l +: 8];
         end
      end

      assign o_rd_data[8*l +: 8] = r_lane[i_rd_addr];
   end
endmodule

// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave memory that stretches every transfer with waitrequest for
// LATENCY cycles; side-band preload port for loading program images.
module avalon_wait_ram
   import avalon_ram_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = DEFAULT_LATENCY
) (
   input  logic              clk,
   input  logic              reset,
   avalon_wait_ram_if.slave  bus,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data,
   output state_e            o_dbg_state
);
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_e            r_state;
   state_e            w_next_state;
   logic [3:0]        r_cnt;
   logic [3:0]        w_next_cnt;
   logic [31:0]       r_readdata;
   logic              w_req;
   logic              w_rd_capture;
   logic [3:0]        w_bus_we;
   logic [ADDR_W-1:0] w_index;
   logic [31:0]       w_mem_rdata;
   logic [31-ADDR_W:0] w_unused_addr_bits;

   assign w_req              = bus.read | bus.write;
   assign w_index            = bus.address[ADDR_W+1:2];
   assign w_unused_addr_bits = {bus.address[31:ADDR_W+2], bus.address[1:0]};

   assign bus.waitrequest = w_req && (r_state != ST_ACK);
   assign bus.readdata    = r_readdata;
   assign o_dbg_state     = r_state;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   // r_cnt is the number of COUNT cycles still owed, including the current one.
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               if (LATENCY == 1) begin
                  w_next_state = ST_ACK;
               end else begin
                  w_next_state = ST_COUNT;
                  w_next_cnt   = CNT_LOAD;
               end
            end
         end
         ST_COUNT: begin
            if (!w_req) begin
               w_next_state = ST_IDLE;
               w_next_cnt   = 4'd0;
            end else if (r_cnt <= 4'd1) begin
               w_next_state = ST_ACK;
               w_next_cnt   = 4'd0;
            end else begin
               w_next_cnt = r_cnt - 4'd1;
            end
         end
         ST_ACK: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
            w_next_cnt   = 4'd0;
         end
      endcase
   end

   // A simultaneous read+write is a write, so only a pure read captures data.
   assign w_rd_capture = (r_state != ST_ACK) && (w_next_state == ST_ACK) &&
                         bus.read && !bus.write;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_readdata <= 32'd0;
      end else if (w_rd_capture) begin
         r_readdata <= w_mem_rdata;
      end
   end

   // Writes commit on the edge leaving ACK; reset in that cycle discards them.
   assign w_bus_we = (r_state == ST_ACK && bus.write && !reset) ? bus.byteenable : 4'b0000;

   byte_lane_mem #(
      .ADDR_W (ADDR_W)
   ) u_mem (
      .i_clk       (clk),
      .i_bus_we    (w_bus_we),
      .i_bus_addr  (w_index),
      .i_bus_wdata (bus.writedata),
      .i_ld_en     (load_en),
      .i_ld_addr   (load_addr),
      .i_ld_data   (load_data),
      .i_rd_addr   (w_index),
      .o_rd_data   (w_mem_rdata)
   );
endmodule

// File: tb/tb_avalon_wait_ram.sv
// Directed bench for avalon_wait_ram: drivers push expected read data into a
// queue that a negedge monitor pops whenever a read is accepted.
module tb_avalon_wait_ram;
   import avalon_ram_pkg::*;

   localparam int ADDR_W  = 10;
   localparam int LATENCY = 2;
   localparam int TMO     = 20;

   logic              clk = 1'b0;
   logic              reset;
   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic [31:0]       load_data;
   state_e            dbg_state;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];

   avalon_wait_ram_if bus_if();

   avalon_wait_ram #(
      .ADDR_W  (ADDR_W),
      .LATENCY (LATENCY)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus_if),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .o_dbg_state (dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Drivers: called just after a rising edge, return just after a rising edge.
   task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(posedge clk);
      #1;
      load_en = 1'b0;
   endtask

   // Checks waitrequest each cycle; ends at the falling edge of the accept cycle.
   task automatic wait_ack(input string name);
      bit done;
      done = 1'b0;
      for (int k = 0; k < TMO && !done; k++) begin
         @(negedge clk);
         check($sformatf("%s waitrequest cycle %0d", name, k), 32'(bus_if.waitrequest),
               (k < LATENCY) ? 32'd1 : 32'd0);
         if (!bus_if.waitrequest) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: waitrequest still 1 after %0d cycles, required 0", name, TMO);
      end
   endtask

   task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
      bus_if.address    = addr;
      bus_if.read       = 1'b1;
      bus_if.write      = 1'b0;
      bus_if.byteenable = 4'b0000;
      exp_q.push_back(exp);
      wait_ack(name);
      @(posedge clk);
      #1;
      bus_if.read = 1'b0;
   endtask

   // action: 0 plain, 1 reset in the accept cycle, 2 preload in the accept cycle
   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be, input string name, input int action,
                            input logic [ADDR_W-1:0] la, input logic [31:0] ld);
      bus_if.address    = addr;
      bus_if.writedata  = data;
      bus_if.byteenable = be;
      bus_if.read       = 1'b0;
      bus_if.write      = 1'b1;
      wait_ack(name);
      #2;
      if (action == 1) reset = 1'b1;
      if (action == 2) begin
         load_en   = 1'b1;
         load_addr = la;
         load_data = ld;
      end
      @(posedge clk);
      #1;
      bus_if.write = 1'b0;
      reset        = 1'b0;
      load_en      = 1'b0;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!reset && bus_if.read && !bus_if.write && !bus_if.waitrequest) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL monitor: unexpected read accept, readdata %08h", bus_if.readdata);
         end else begin
            check("readdata", bus_if.readdata, exp_q.pop_front());
         end
      end
   end

   initial begin
      reset             = 1'b1;
      load_en           = 1'b0;
      load_addr         = '0;
      load_data         = '0;
      bus_if.address    = '0;
      bus_if.read       = 1'b0;
      bus_if.write      = 1'b0;
      bus_if.byteenable = '0;
      bus_if.writedata  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset state", 32'(dbg_state), 32'(ST_IDLE));
      check("reset readdata", bus_if.readdata, 32'h0);
      check("reset waitrequest", 32'(bus_if.waitrequest), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // preload then read byte address 4 (word 1)
      preload(10'd1, 32'h240ABFC0);
      bus_read(32'h0000_0004, 32'h240ABFC0, "rd_word1");

      // lanes 0 and 2 take DD and BB from the write data
      preload(10'd5, 32'h11223344);
      bus_write(32'h0000_0014, 32'hAABBCCDD, 4'b0101, "wr_be0101", 0, '0, '0);
      bus_read(32'h0000_0014, 32'h11BB33DD, "rd_be0101");
      bus_write(32'h0000_0014, 32'h00000000, 4'b0000, "wr_be0000", 0, '0, '0);
      bus_read(32'h0000_0014, 32'h11BB33DD, "rd_be0000");

      // aliasing of upper address bits and address wrap
      bus_write(32'h0000_0010, 32'hDEADBEEF, 4'b1111, "wr_alias", 0, '0, '0);
      bus_read(MIPS_RESET_VECTOR | 32'h10, 32'hDEADBEEF, "rd_alias");
      bus_read(32'h0000_1004, 32'h240ABFC0, "rd_wrap");

      // reset during the accept cycle of a write
      preload(10'd8, 32'hCAFEF00D);
      bus_read(32'h0000_0020, 32'hCAFEF00D, "rd_pre_reset");
      bus_write(32'h0000_0020, 32'h12345678, 4'b1111, "wr_reset_ack", 1, '0, '0);
      @(negedge clk);
      check("state after reset in ack", 32'(dbg_state), 32'(ST_IDLE));
      check("readdata after reset in ack", bus_if.readdata, 32'h0);
      @(posedge clk);
      #1;
      bus_read(32'h0000_0020, 32'hCAFEF00D, "rd_post_reset");

      // read dropped during its COUNT cycle, then a fresh read
      preload(10'd9, 32'h0BADF00D);
      bus_if.address = 32'h0000_0024;
      bus_if.read    = 1'b1;
      @(negedge clk);
      check("drop waitrequest cycle 0", 32'(bus_if.waitrequest), 32'd1);
      @(negedge clk);
      check("drop waitrequest cycle 1", 32'(bus_if.waitrequest), 32'd1);
      check("drop state in count", 32'(dbg_state), 32'(ST_COUNT));
      #2;
      bus_if.read = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("state after drop", 32'(dbg_state), 32'(ST_IDLE));
      check("readdata after drop", bus_if.readdata, 32'hCAFEF00D);
      @(posedge clk);
      #1;
      bus_read(32'h0000_0024, 32'h0BADF00D, "rd_after_drop");

      // preload and bus write to the same word on the same edge
      bus_write(32'h0000_0030, 32'hFFFFFFFF, 4'b1111, "wr_collide", 2, 10'd12, 32'h0000CAFE);
      bus_read(32'h0000_0030, 32'h0000CAFE, "rd_collide");

      repeat (3) @(posedge clk);
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
